// File: rtl/cordic_arb_ctrl.sv
// Two-requester round-robin front end for a rec2pol CORDIC core: it latches the operands,
// sequences start/iterate, and holds the result until the consumer takes it.
module cordic_arb_ctrl #(
  parameter int unsigned NITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        req1_ready,
  output logic        core_start,
  output logic        core_enable,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  input  logic [31:0] core_mod,
  input  logic [31:0] core_angle,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic        res_err,
  output logic [31:0] res_mod,
  output logic [31:0] res_angle,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam logic [5:0] ITER_LAST = 6'(NITER - 1);

  state_t      state, state_next;
  logic        last_id;
  logic [5:0]  iter;
  logic        grant0, grant1;
  logic        accept, accept_id, bad_op;
  logic [31:0] acc_x, acc_y;

  always_comb begin
    // On contention the requester not served last wins.
    grant0     = req0_valid & (~req1_valid | last_id);
    grant1     = req1_valid & (~req0_valid | ~last_id);
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
    accept_id  = req1_ready;
    acc_x      = accept_id ? req1_x : req0_x;
    acc_y      = accept_id ? req1_y : req0_y;
    bad_op     = acc_x[31] | (acc_x == '0);

    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad_op ? DONE : START;
      START:   state_next = RUN;
      RUN:     if (iter == ITER_LAST) state_next = DONE;
      DONE:    if (res_valid & res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_id     <= 1'b1;
      iter        <= '0;
      core_start  <= 1'b0;
      core_enable <= 1'b0;
      core_x      <= '0;
      core_y      <= '0;
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_err     <= 1'b0;
      res_mod     <= '0;
      res_angle   <= '0;
      busy        <= 1'b0;
    end else begin
      core_start  <= (state_next == START);
      core_enable <= (state_next == START) || (state_next == RUN);
      busy        <= (state_next != IDLE);

      if (accept) begin
        core_x  <= acc_x;
        core_y  <= acc_y;
        res_id  <= accept_id;
        last_id <= accept_id;
        if (bad_op) begin
          res_err   <= 1'b1;
          res_mod   <= '0;
          res_angle <= '0;
        end
      end

      if (state == START)    iter <= '0;
      else if (state == RUN) iter <= iter + 6'd1;

      if (state == RUN && iter == ITER_LAST) begin
        res_mod   <= core_mod;
        res_angle <= core_angle;
        res_err   <= 1'b0;
        res_valid <= 1'b1;
      end

      // An error operand enters DONE with res_valid still low; it rises one cycle later.
      if (state == DONE) begin
        if (res_valid & res_ready) res_valid <= 1'b0;
        else if (!res_valid)       res_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_arb_ctrl.sv
// Directed bench for cordic_arb_ctrl; a stand-in core whose outputs drift with each enabled
// cycle, so only a capture on the right edge yields the expected modulus and angle.
module tb_cordic_arb_ctrl;

  localparam int NITER = 8;
  localparam logic [31:0] MOD_EXP = 32'h0005_0000;
  localparam logic [31:0] ANG_EXP = 32'd891375203;  // 53.1301 deg in 8Q24

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        req0_ready, req1_ready;
  logic        core_start, core_enable;
  logic [31:0] core_x, core_y, core_mod, core_angle;
  logic        res_valid, res_ready = 1'b0, res_id, res_err, busy;
  logic [31:0] res_mod, res_angle;

  int n_vec = 0;
  int n_err = 0;
  int unsigned ecnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (core_start)       ecnt <= 1;
    else if (core_enable) ecnt <= ecnt + 1;
  end
  assign core_mod   = MOD_EXP - 32'(NITER) + 32'(ecnt);
  assign core_angle = ANG_EXP - 32'(NITER) + 32'(ecnt);

  cordic_arb_ctrl #(.NITER(NITER)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
    .core_start(core_start), .core_enable(core_enable), .core_x(core_x), .core_y(core_y),
    .core_mod(core_mod), .core_angle(core_angle),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_err(res_err),
    .res_mod(res_mod), .res_angle(res_angle), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_op(input logic id, input logic [31:0] x, input logic [31:0] y,
                       input logic exp_err);
    int cyc, n_st, n_en;
    logic seen;
    @(negedge clock);
    res_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    #1;
    check("op_ready", 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("op_core_x", core_x, x);
    check("op_core_y", core_y, y);
    cyc = 0; n_st = 0; n_en = 0; seen = 1'b0;
    while (!seen && cyc < NITER + 20) begin
      if (res_valid) seen = 1'b1;
      else begin
        n_st += 32'(core_start);
        n_en += 32'(core_enable);
        @(negedge clock);
        cyc++;
      end
    end
    check("op_res_valid", 32'(seen), 32'd1);
    check("op_latency", 32'(cyc), exp_err ? 32'd1 : 32'(NITER + 1));
    check("op_start_cycles", 32'(n_st), exp_err ? 32'd0 : 32'd1);
    check("op_enable_cycles", 32'(n_en), exp_err ? 32'd0 : 32'(NITER + 1));
    check("op_res_id", 32'(res_id), 32'(id));
    check("op_res_err", 32'(res_err), 32'(exp_err));
    check("op_res_mod", res_mod, exp_err ? 32'd0 : MOD_EXP);
    check("op_res_angle", res_angle, exp_err ? 32'd0 : ANG_EXP);
    check("op_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("op_res_valid_clr", 32'(res_valid), 32'd0);
    check("op_busy_clr", 32'(busy), 32'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    int gap;
    logic g;
    logic seen;

    // Reset state
    apply_reset();
    check("rst_ctrl", 32'({core_start, core_enable, res_valid, res_err, res_id, busy}), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_core_x", core_x, 32'd0);
    check("rst_core_y", core_y, 32'd0);
    check("rst_res_mod", res_mod, 32'd0);
    check("rst_res_angle", res_angle, 32'd0);

    // Single legal request, then boundary operands
    do_op(1'b0, 32'h0003_0000, 32'h0004_0000, 1'b0);
    do_op(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
    do_op(1'b0, 32'h0000_0000, 32'h0005_0000, 1'b1);
    do_op(1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    // Contention: both continuously valid, grants alternate starting with 0
    apply_reset();
    @(negedge clock);
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 32'h0001_0000; req0_y = 32'h0000_1000;
    req1_valid = 1'b1; req1_x = 32'h0002_0000; req1_y = 32'h0000_2000;
    #1;
    gap = 0;
    for (int op = 0; op < 4; op++) begin
      while (!(req0_ready | req1_ready) && gap < NITER + 10) begin
        @(negedge clock);
        #1;
        gap++;
      end
      check("cont_grant", 32'({req1_ready, req0_ready}), (op % 2) ? 32'd2 : 32'd1);
      if (op > 0) check("cont_spacing", 32'(gap), 32'(NITER + 3));
      g = req1_ready;
      @(negedge clock);
      gap = 1;
      check("cont_core_x", core_x, g ? 32'h0002_0000 : 32'h0001_0000);
      while (!res_valid && gap < NITER + 10) begin
        @(negedge clock);
        gap++;
      end
      check("cont_res_valid", 32'(res_valid), 32'd1);
      check("cont_res_id", 32'(res_id), 32'(g));
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);

    // Backpressure: result held with both requesters pending
    @(negedge clock);
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 32'h0003_0000; req0_y = 32'h0004_0000;
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_x = 32'h0007_0000; req1_y = 32'h0000_0000;
    gap = 0;
    while (!res_valid && gap < NITER + 10) begin
      @(negedge clock);
      gap++;
    end
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1;
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_mod", res_mod, MOD_EXP);
      check("bp_res_angle", res_angle, ANG_EXP);
      check("bp_res_id_err", 32'({res_id, res_err}), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clock);
    end
    req0_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clock);
    #1;
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_valid", 32'(res_valid), 32'd0);
    check("bp_no_accept", core_x, 32'h0003_0000);
    check("bp_idle_ready", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    res_ready = 1'b0;

    // Reset in the middle of RUN
    @(negedge clock);
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 32'h0003_0000; req0_y = 32'h0004_0000;
    @(negedge clock);
    req0_valid = 1'b0;
    repeat (1 + NITER / 2) @(negedge clock);
    check("mid_run_active", 32'({busy, core_enable, core_start}), 32'd6);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_ctrl", 32'({core_start, core_enable, res_valid, res_err, res_id, busy}), 32'd0);
    check("mid_rst_core_x", core_x, 32'd0);
    check("mid_rst_res_mod", res_mod, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (NITER + 5) begin
      @(negedge clock);
      if (res_valid || busy) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    do_op(1'b0, 32'h0003_0000, 32'h0004_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
